serial_subtractor: RTL

// Bit-serial WIDTH-bit subtractor: the inverse operation to the fulladder arithmetic path.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit a-b, LSB first, one full-subtractor
// cell plus a borrow flop, with a start/done handshake.
// Ports: clk, rst_n (async active-low), start, a, b -> busy, done, diff, borrowout
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrowout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_a_sr doubles as the result register: as minuend bits leave
  // at the LSB, difference bits enter at the MSB.
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  assign w_x       = r_a_sr[0];
  assign w_y       = r_b_sr[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_res     = {w_d, r_a_sr[WIDTH-1:1]};
  assign w_accept  = start &&
                     (r_state == S_IDLE || r_state == S_DONE);
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_cnt  <= '0;
      r_br   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr <= w_res;
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_cnt  <= r_cnt + CW'(1);
      r_br   <= w_br_next;
      // Final bit goes straight to the outputs so diff only
      // ever shows a complete result.
      if (w_last) begin
        r_diff <= w_res;
        r_bout <= w_br_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last bit-cycle x and y are the original operand MSBs
  // and d is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (w_x != w_y) && (w_d != w_x);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrowout = r_bout;

endmodule
